// File: rtl/scrambled_transmitter.sv
// Serial transmitter: one-word holding register, MSB-first serialiser, XORed with a 3-bit LFSR
// keystream. All-ones preamble before the first frame after reset, zero gaps between frames.
module scrambled_transmitter #(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned PRE_LEN = 4,
  parameter int unsigned GAP_LEN = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              BIT_EN,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              SOUT,
  output logic              BUSY,
  output logic              UNDERRUN
);

  localparam int unsigned MaxPd  = (DATA_W > PRE_LEN) ? DATA_W : PRE_LEN;
  localparam int unsigned MaxLen = (MaxPd > GAP_LEN) ? MaxPd : GAP_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  localparam logic [CntW-1:0] PreLast  = CntW'(PRE_LEN - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_LEN - 1);

  typedef enum logic [1:0] {StIdle, StPre, StPay, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        lfsr_q, lfsr_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              sout_q, sout_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;

  logic [2:0]        lfsr_step;
  logic              key;
  logic              load;
  logic [DATA_W-1:0] load_word;

  always_comb begin
    lfsr_step   = {lfsr_q[1:0], lfsr_q[0] ^ lfsr_q[2]};
    key         = lfsr_step[2];
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sout_d      = sout_q;
    underrun_d  = 1'b0;
    load        = 1'b0;
    load_word   = '0;

    if (BIT_EN) begin
      unique case (state_q)
        StIdle: begin
          if (hold_full_q) begin
            state_d = StPre;
            cnt_d   = '0;
            sout_d  = 1'b1;
          end else begin
            sout_d = 1'b0;
          end
        end
        StPre: begin
          if (cnt_q == PreLast) begin
            load = 1'b1;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            sout_d = 1'b1;
          end
        end
        StPay: begin
          if (cnt_q == DataLast) begin
            state_d = StGap;
            cnt_d   = '0;
            sout_d  = 1'b0;
          end else begin
            shreg_d = shreg_q << 1;
            sout_d  = shreg_q[DATA_W-2] ^ key;
            lfsr_d  = lfsr_step;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            load       = 1'b1;
            underrun_d = !hold_full_q;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            sout_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Payload start: an empty holding register sends scrambled zeros instead.
    if (load) begin
      load_word   = hold_full_q ? hold_q : '0;
      state_d     = StPay;
      cnt_d       = '0;
      shreg_d     = load_word;
      sout_d      = load_word[DATA_W-1] ^ key;
      lfsr_d      = lfsr_step;
      hold_full_d = 1'b0;
    end

    // Accept is gated by the pre-edge READY, so it never collides with a real consume.
    if (DIN_VALID && !hold_full_q) begin
      hold_d      = DIN;
      hold_full_d = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lfsr_q      <= 3'b111;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sout_q      <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sout_q      <= sout_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign DIN_READY = !hold_full_q;
  assign SOUT      = sout_q;
  assign BUSY      = busy_q;
  assign UNDERRUN  = underrun_q;

endmodule
